sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer, successor to the fixed 4-bit SIPO shift register.
- Adds a bit-enable strobe, a selectable shift direction, a word-framing bit counter, a valid/ready output handshake, an overrun flag and a synchronous flush.
- Sits between a serial bit source (line receiver, bit-banged interface) and a parallel word consumer.

Parameters:
WIDTH, 4, word width in bits; legal range 2..64.
LSB_FIRST, 0, 0 = first bit received lands in qout[WIDTH-1] (MSB first); 1 = first bit lands in qout[0].

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush; priority over every other input except reset.
din  input  1  serial data bit.
din_en  input  1  when high, din is sampled on this rising edge.
shift_q  output  WIDTH  live shift-register contents, updated every accepted bit.
qout  output  WIDTH  captured word; held stable while out_valid=1.
out_valid  output  1  qout holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high on an edge.
bit_cnt  output  CW  bits received in the current word, 0..WIDTH-1; CW = clog2(WIDTH).
overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (async): shift_q=0, qout=0, out_valid=0, bit_cnt=0, overrun=0.
- clear=1 on an edge: same values as reset. din_en, din and out_ready are ignored that cycle.
- Shift, din_en=1:
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], din}.
  - LSB_FIRST=1: sr <= {din, sr[WIDTH-1:1]}.
- din_en=0: sr and bit_cnt hold.
- Counter: bit_cnt increments on each accepted bit and wraps from WIDTH-1 to 0. No bits are lost at the wrap; the next word starts on the following bit.
- Word completion: din_en=1 with bit_cnt==WIDTH-1. The completed word is the post-shift sr value (includes the current din).
- Capture rule on completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 on the same edge: qout <= completed word and out_valid <= 1.
  - Otherwise: the word is dropped, qout is unchanged and overrun <= 1.
- Latency: out_valid rises on the same edge that samples the WIDTH-th bit, so it is visible one cycle after that bit is presented.
- Handshake:
  - out_valid && out_ready with no completion that edge: out_valid <= 0 and qout holds its old value.
  - Accept and completion on the same edge: out_valid stays 1 and qout takes the new word (back-to-back, no bubble).
  - out_ready while out_valid=0 has no effect.
- overrun: cleared only by reset or clear. Further drops leave it at 1.
- Reset or clear mid-word: the partial word is discarded and the next accepted bit counts as bit 0.
- The shift register is not zeroed between words; shift_q always shows the last WIDTH received bits.

Decomposition:
- Package sipo_pkg:
  - function cnt_width(w) returning clog2(w), with a minimum of 1.
  - localparam-friendly constants MSB_FIRST=0 and LSB_FIRST=1.
- Sub-module sipo_shift_core (WIDTH, LSB_FIRST): direction-selectable shift register plus bit counter.
  - Ports: clock, reset, clear, din, din_en, sr, bit_cnt, word_done.
  - word_done is the combinational completion strobe.
- Top level sipo_deserializer owns the qout/out_valid/overrun handshake logic.

Test Plan:
1. WIDTH=4, LSB_FIRST=0, out_ready=1, din_en=1: bits 0,0,1,1 -> out_valid pulses for 1 cycle with qout=4'b0011; bit_cnt sequence 1,2,3,0.
2. WIDTH=4, LSB_FIRST=1: bits 1,0,0,0 -> qout=4'b0001; then 1,1,1,1 -> qout=4'b1111 with out_valid high on consecutive word edges; no overrun.
3. out_ready=0, stream 8 bits 1,0,1,0,0,1,0,1 -> qout=4'b1010 held, out_valid stays 1, overrun=1 after the 8th bit. Raise out_ready for 1 cycle -> out_valid=0, overrun remains 1.
4. Back-to-back: out_ready asserted exactly on the edge completing word 2 -> out_valid stays 1 and qout switches from word 1 to word 2 with no idle cycle.
5. din_en gapped (1,0,0,1,...) with bits 1,1,0,1 -> qout=4'b1101; bit_cnt and shift_q hold during gaps.
6. After 2 bits, assert reset asynchronously between edges -> all outputs 0 immediately. Repeat with clear -> outputs 0 after the edge, and the next 4 bits form a complete word.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

  localparam int MSB_FIRST = 0;
  localparam int LSB_FIRST = 1;

  // Counter width for a word of w bits; never narrower than one bit.
  function automatic int cnt_width(input int w);
    int n;
    n = $clog2(w);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Direction-selectable shift register with word-framing bit counter.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = MSB_FIRST,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] sr,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [CW-1:0]    r_cnt;
  logic             w_last;

  assign w_sr_next = (LSB_FIRST == sipo_pkg::LSB_FIRST) ? {din, r_sr[WIDTH-1:1]}
                                                         : {r_sr[WIDTH-2:0], din};
  assign w_last    = (r_cnt == LAST_BIT);
  assign word_done = din_en && !clear && w_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (din_en) begin
      r_sr  <= w_sr_next;
      // Explicit wrap so non-power-of-two widths frame correctly.
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign sr      = r_sr;
  assign bit_cnt = r_cnt;

endmodule

// File: rtl/sipo_deserializer.sv
// Parametrised SIPO deserializer: shift core plus valid/ready word capture and sticky overrun.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = MSB_FIRST,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] shift_q,
  output logic [WIDTH-1:0] qout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_word;
  logic             w_word_done;
  logic             w_can_load;
  logic [WIDTH-1:0] r_qout;
  logic             r_valid;
  logic             r_overrun;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .din      (din),
    .din_en   (din_en),
    .sr       (w_sr),
    .bit_cnt  (bit_cnt),
    .word_done(w_word_done)
  );

  // The captured word includes the bit arriving on the completing edge.
  assign w_word     = (LSB_FIRST == sipo_pkg::LSB_FIRST) ? {din, w_sr[WIDTH-1:1]}
                                                          : {w_sr[WIDTH-2:0], din};
  assign w_can_load = !r_valid || out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_qout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_qout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_word_done) begin
      if (w_can_load) begin
        r_qout  <= w_word;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign shift_q   = w_sr;
  assign qout      = r_qout;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances on shared inputs.
module tb_sipo_deserializer;

  logic       clock, reset, clear, din, din_en, out_ready;
  logic [3:0] sq0, q0, sq1, q1;
  logic [1:0] bc0, bc1;
  logic       v0, ov0, v1, ov1;
  int         tests, fails;

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .din(din), .din_en(din_en),
    .shift_q(sq0), .qout(q0), .out_valid(v0), .out_ready(out_ready),
    .bit_cnt(bc0), .overrun(ov0)
  );

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .din(din), .din_en(din_en),
    .shift_q(sq1), .qout(q1), .out_valid(v1), .out_ready(out_ready),
    .bit_cnt(bc1), .overrun(ov1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic send(input logic b);
    din    = b;
    din_en = 1'b1;
    @(posedge clock); #1;
    din_en = 1'b0;
  endtask

  task automatic idle();
    din_en = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; din = 1'b0; din_en = 1'b0; out_ready = 1'b0;
    #12;
    tests++; if ({sq0, q0, v0, bc0, ov0} !== 12'h0) begin fails++; $display("FAIL reset_dut0 got %h want 000", {sq0, q0, v0, bc0, ov0}); end
    tests++; if ({sq1, q1, v1, bc1, ov1} !== 12'h0) begin fails++; $display("FAIL reset_dut1 got %h want 000", {sq1, q1, v1, bc1, ov1}); end
    reset = 1'b0;
  endtask

  task automatic test_msb_first();
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       bits    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(bits[i]);
      tests++; if (bc0 !== exp_cnt[i]) begin fails++; $display("FAIL msb_cnt[%0d] got %0d want %0d", i, bc0, exp_cnt[i]); end
      if (i < 3) begin
        tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL msb_early_valid[%0d] got %b want 0", i, v0); end
      end
    end
    tests++; if (v0 !== 1'b1 || q0 !== 4'b0011) begin fails++; $display("FAIL msb_word got v=%b q=%b want v=1 q=0011", v0, q0); end
    idle();
    tests++; if (v0 !== 1'b0 || q0 !== 4'b0011) begin fails++; $display("FAIL msb_pulse got v=%b q=%b want v=0 q=0011", v0, q0); end
    out_ready = 1'b0;
  endtask

  task automatic test_lsb_first();
    do_clear();
    out_ready = 1'b1;
    send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    tests++; if (v1 !== 1'b1 || q1 !== 4'b0001) begin fails++; $display("FAIL lsb_word1 got v=%b q=%b want v=1 q=0001", v1, q1); end
    send(1'b1); send(1'b1); send(1'b1); send(1'b1);
    tests++; if (v1 !== 1'b1 || q1 !== 4'b1111) begin fails++; $display("FAIL lsb_word2 got v=%b q=%b want v=1 q=1111", v1, q1); end
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL lsb_no_overrun got %b want 0", ov1); end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(bits[i]);
      if (i == 6) begin
        tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL ovr_early got %b want 0", ov0); end
      end
    end
    tests++; if (v0 !== 1'b1 || q0 !== 4'b1010) begin fails++; $display("FAIL ovr_held got v=%b q=%b want v=1 q=1010", v0, q0); end
    tests++; if (ov0 !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", ov0); end
    tests++; if (sq0 !== 4'b0101) begin fails++; $display("FAIL ovr_shift got %b want 0101", sq0); end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    tests++; if (v0 !== 1'b0 || ov0 !== 1'b1) begin fails++; $display("FAIL ovr_drain got v=%b ov=%b want v=0 ov=1", v0, ov0); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b0;
    send(1'b1); send(1'b1); send(1'b0); send(1'b0);
    tests++; if (v0 !== 1'b1 || q0 !== 4'b1100) begin fails++; $display("FAIL b2b_word1 got v=%b q=%b want v=1 q=1100", v0, q0); end
    send(1'b0); send(1'b1); send(1'b1);
    tests++; if (v0 !== 1'b1 || q0 !== 4'b1100) begin fails++; $display("FAIL b2b_hold got v=%b q=%b want v=1 q=1100", v0, q0); end
    out_ready = 1'b1;
    send(1'b0);
    tests++; if (v0 !== 1'b1 || q0 !== 4'b0110 || ov0 !== 1'b0) begin fails++; $display("FAIL b2b_word2 got v=%b q=%b ov=%b want v=1 q=0110 ov=0", v0, q0, ov0); end
    idle();
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL b2b_drain got v=%b want 0", v0); end
    out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    do_clear();
    out_ready = 1'b1;
    send(1'b1);
    din = 1'b1; idle(); din = 1'b0; idle();
    tests++; if (bc0 !== 2'd1 || sq0 !== 4'b0001) begin fails++; $display("FAIL gap1 got cnt=%0d sq=%b want cnt=1 sq=0001", bc0, sq0); end
    send(1'b1);
    din = 1'b0; idle();
    tests++; if (bc0 !== 2'd2 || sq0 !== 4'b0011) begin fails++; $display("FAIL gap2 got cnt=%0d sq=%b want cnt=2 sq=0011", bc0, sq0); end
    send(1'b0);
    send(1'b1);
    tests++; if (v0 !== 1'b1 || q0 !== 4'b1101 || bc0 !== 2'd0) begin fails++; $display("FAIL gap_word got v=%b q=%b cnt=%0d want v=1 q=1101 cnt=0", v0, q0, bc0); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_clear();
    out_ready = 1'b1;
    send(1'b1); send(1'b1);
    tests++; if (bc0 !== 2'd2 || sq0 !== 4'b0011) begin fails++; $display("FAIL pre_rst got cnt=%0d sq=%b want cnt=2 sq=0011", bc0, sq0); end
    #2 reset = 1'b1;
    #1;
    tests++; if ({sq0, q0, v0, bc0, ov0} !== 12'h0) begin fails++; $display("FAIL async_rst got %h want 000", {sq0, q0, v0, bc0, ov0}); end
    reset = 1'b0;
    @(posedge clock); #1;
    send(1'b1); send(1'b1);
    clear = 1'b1; din = 1'b1; din_en = 1'b1;
    #1;
    tests++; if (bc0 !== 2'd2) begin fails++; $display("FAIL clr_sync got cnt=%0d want 2", bc0); end
    @(posedge clock); #1;
    clear = 1'b0; din_en = 1'b0;
    tests++; if ({sq0, q0, v0, bc0, ov0} !== 12'h0) begin fails++; $display("FAIL clr_state got %h want 000", {sq0, q0, v0, bc0, ov0}); end
    send(1'b1); send(1'b0); send(1'b1);
    tests++; if (v0 !== 1'b0 || bc0 !== 2'd3) begin fails++; $display("FAIL clr_partial got v=%b cnt=%0d want v=0 cnt=3", v0, bc0); end
    send(1'b1);
    tests++; if (v0 !== 1'b1 || q0 !== 4'b1011) begin fails++; $display("FAIL clr_word got v=%b q=%b want v=1 q=1011", v0, q0); end
    out_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_gapped();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
